// File: rtl/regfile_writeback_if.sv
// Register-file port bundle: one write port from MEM/WB, two read ports to ID.
// The master drives indices and write data; the slave returns operands.
interface regfile_writeback_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              bypass1;
  logic              bypass2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2,
    input  bypass1,
    input  bypass2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2,
    output bypass1,
    output bypass2
  );
endinterface

// File: rtl/regfile_writeback.sv
// LEGv8 32x64 register file: one synchronous write port, two combinational
// read ports with same-cycle write-through bypass; X31 (XZR) reads as zero.
module regfile_writeback #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  rf
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS-1];
  logic [DATA_W-1:0] regs_d [NREGS-1];
  logic              wr_en;

  // XZR has no storage, so writes addressed to it are dropped here.
  assign wr_en = rf.RegWrite && (rf.WriteRegister != XZR);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rf.WriteRegister] = rf.WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is gated by reset so the outputs stay quiet while it is held.
  always_comb begin
    rf.ReadData1 = '0;
    rf.bypass1   = 1'b0;
    if (reset || rf.ReadRegister1 == XZR) begin
      rf.ReadData1 = '0;
    end else if (rf.RegWrite &&
                 rf.WriteRegister == rf.ReadRegister1) begin
      rf.ReadData1 = rf.WriteData;
      rf.bypass1   = 1'b1;
    end else begin
      rf.ReadData1 = regs_q[rf.ReadRegister1];
    end
  end

  always_comb begin
    rf.ReadData2 = '0;
    rf.bypass2   = 1'b0;
    if (reset || rf.ReadRegister2 == XZR) begin
      rf.ReadData2 = '0;
    end else if (rf.RegWrite &&
                 rf.WriteRegister == rf.ReadRegister2) begin
      rf.ReadData2 = rf.WriteData;
      rf.bypass2   = 1'b1;
    end else begin
      rf.ReadData2 = regs_q[rf.ReadRegister2];
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus a
// randomized run against an array model of the architectural registers.
module tb_regfile_writeback;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  logic [63:0] mdl [32];

  regfile_writeback_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_writeback #(
    .DATA_W(64), .NREGS(32), .ADDR_W(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_data(
    input logic [4:0] ra);
    if (reset || ra == 5'd31) return 64'd0;
    if (bus.RegWrite && bus.WriteRegister == ra)
      return bus.WriteData;
    return mdl[ra];
  endfunction

  function automatic logic exp_byp(input logic [4:0] ra);
    if (reset || ra == 5'd31) return 1'b0;
    return bus.RegWrite && bus.WriteRegister == ra;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2);
    bus.RegWrite      = we;
    bus.WriteRegister = wa;
    bus.WriteData     = wd;
    bus.ReadRegister1 = r1;
    bus.ReadRegister2 = r2;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (!reset && bus.RegWrite && bus.WriteRegister != 5'd31)
      mdl[bus.WriteRegister] = bus.WriteData;
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_model();
    drive(1'b1, 5'd6, 64'h5555, 5'd6, 5'd6);
    edge_step();
    total++;
    if (bus.ReadData1 !== 64'd0 || bus.bypass1 !== 1'b0) begin
      $display("FAIL reset_rd1 got %h/%b want 0/0",
               bus.ReadData1, bus.bypass1);
    end else passed++;
    total++;
    if (bus.ReadData2 !== 64'd0 || bus.bypass2 !== 1'b0) begin
      $display("FAIL reset_rd2 got %h/%b want 0/0",
               bus.ReadData2, bus.bypass2);
    end else passed++;
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 5'd6, 5'd0);
    total++;
    if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0) begin
      $display("FAIL reset_regs got %h %h want 0 0",
               bus.ReadData1, bus.ReadData2);
    end else passed++;
  endtask

  task automatic test_reset_clear();
    drive(1'b1, 5'd5, 64'hDEAD, 5'd0, 5'd0);
    edge_step();
    drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    total++;
    if (bus.ReadData1 !== 64'hDEAD) begin
      $display("FAIL clear_pre got %h want %h",
               bus.ReadData1, 64'hDEAD);
    end else passed++;
    #1 reset = 1'b1;
    #1;
    clear_model();
    total++;
    if (bus.ReadData1 !== 64'd0) begin
      $display("FAIL clear_async got %h want 0", bus.ReadData1);
    end else passed++;
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.ReadData2 !== 64'd0) begin
      $display("FAIL clear_after got %h want 0", bus.ReadData2);
    end else passed++;
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd3, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd0);
    edge_step();
    drive(1'b0, 5'd3, 64'd0, 5'd3, 5'd0);
    total++;
    if (bus.ReadData1 !== 64'h1234_5678_9ABC_DEF0 ||
        bus.bypass1 !== 1'b0) begin
      $display("FAIL basic got %h/%b want %h/0", bus.ReadData1,
               bus.bypass1, 64'h1234_5678_9ABC_DEF0);
    end else passed++;
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    edge_step();
    drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
    total++;
    if (bus.ReadData1 !== 64'h22 || bus.ReadData2 !== 64'h22 ||
        bus.bypass1 !== 1'b1 || bus.bypass2 !== 1'b1) begin
      $display("FAIL bypass got %h %h %b%b want 22 22 11",
               bus.ReadData1, bus.ReadData2,
               bus.bypass1, bus.bypass2);
    end else passed++;
    edge_step();
    drive(1'b0, 5'd7, 64'h0, 5'd7, 5'd7);
    total++;
    if (bus.ReadData1 !== 64'h22 || bus.ReadData2 !== 64'h22 ||
        bus.bypass1 !== 1'b0 || bus.bypass2 !== 1'b0) begin
      $display("FAIL bypass_after got %h %h %b%b want 22 22 00",
               bus.ReadData1, bus.ReadData2,
               bus.bypass1, bus.bypass2);
    end else passed++;
  endtask

  task automatic test_xzr();
    drive(1'b1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
    for (int e = 0; e < 2; e++) begin
      total++;
      if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0 ||
          bus.bypass1 !== 1'b0 || bus.bypass2 !== 1'b0) begin
        $display("FAIL xzr_%0d got %h %h %b%b want 0 0 00", e,
                 bus.ReadData1, bus.ReadData2,
                 bus.bypass1, bus.bypass2);
      end else passed++;
      edge_step();
    end
    bus.RegWrite = 1'b0;
    for (int r = 0; r < 31; r++) begin
      drive(1'b0, 5'd0, 64'd0, 5'(r), 5'(30 - r));
      total++;
      if (bus.ReadData1 !== mdl[r] ||
          bus.ReadData2 !== mdl[30 - r]) begin
        $display("FAIL xzr_keep r%0d got %h %h want %h %h", r,
                 bus.ReadData1, bus.ReadData2, mdl[r], mdl[30 - r]);
      end else passed++;
    end
  endtask

  task automatic test_split();
    drive(1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
    edge_step();
    drive(1'b1, 5'd2, 64'hAA, 5'd2, 5'd4);
    total++;
    if (bus.ReadData1 !== 64'hAA || bus.bypass1 !== 1'b1 ||
        bus.ReadData2 !== 64'h44 || bus.bypass2 !== 1'b0) begin
      $display("FAIL split got %h/%b %h/%b want aa/1 44/0",
               bus.ReadData1, bus.bypass1,
               bus.ReadData2, bus.bypass2);
    end else passed++;
    edge_step();
  endtask

  task automatic test_reset_vs_write();
    drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9);
    reset = 1'b1;
    clear_model();
    #1;
    total++;
    if (bus.ReadData1 !== 64'd0 || bus.bypass1 !== 1'b0) begin
      $display("FAIL rvw_during got %h/%b want 0/0",
               bus.ReadData1, bus.bypass1);
    end else passed++;
    edge_step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
    total++;
    if (bus.ReadData1 !== 64'd0) begin
      $display("FAIL rvw got %h want 0", bus.ReadData1);
    end else passed++;
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] wd;
    int          errs;
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 3) != 0);
      wa = 5'($urandom);
      wd = {$urandom, $urandom};
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      drive(we, wa, wd, r1, r2);
      total++;
      if (bus.ReadData1 !== exp_data(r1) ||
          bus.bypass1 !== exp_byp(r1) ||
          bus.ReadData2 !== exp_data(r2) ||
          bus.bypass2 !== exp_byp(r2)) begin
        if (errs < 10)
          $display("FAIL rand_%0d got %h/%b %h/%b want %h/%b %h/%b",
                   n, bus.ReadData1, bus.bypass1,
                   bus.ReadData2, bus.bypass2,
                   exp_data(r1), exp_byp(r1),
                   exp_data(r2), exp_byp(r2));
        errs++;
      end else passed++;
      edge_step();
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    clear_model();
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    @(negedge clk);
    test_reset();
    test_reset_clear();
    test_basic();
    test_bypass();
    test_xzr();
    test_split();
    test_reset_vs_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
